// File: rtl/pixel_streamer.sv
// pixel_streamer: reads one IMG_HEIGHT x IMG_WIDTH frame from a sync-read buffer and streams it in raster order
// Ports: clk, rst_n (sync, active low); start/pause requests; busy/done status;
//        mem_rd_en/mem_addr/mem_rd_data frame-buffer read port (1-cycle latency);
//        frame_start/pixel_out/pixel_valid stream to the window stage.
// Optional ROW_GAP_EN macro: insert ROW_GAP idle cycles after every row but the last.
module pixel_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 5,
   parameter int IMG_HEIGHT = 5,
   parameter int ADDR_WIDTH = 5,
   parameter int ROW_GAP    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pause,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  frame_start,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_valid
);
   localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
   localparam int GW = ROW_GAP > 0 ? $clog2(ROW_GAP + 1) : 1;
`ifdef ROW_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, SOF, STREAM, GAP, DRAIN} state_t;
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CW-1:0]           col_q, col_d;
   logic [RW-1:0]           row_q, row_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    fs_q, fs_d;
   logic                    rd_d1_q, rd_d1_d;
   logic                    pv_q, pv_d;
   logic [DATA_WIDTH-1:0]   pix_q, pix_d;
   logic                    col_last, row_last;
   assign col_last    = col_q == CW'(IMG_WIDTH - 1);
   assign row_last    = row_q == RW'(IMG_HEIGHT - 1);
   assign mem_rd_en   = (state_q == STREAM) && !pause;
   assign mem_addr    = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frame_start = fs_q;
   assign pixel_out   = pix_q;
   assign pixel_valid = pv_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      col_d   = col_q;
      row_d   = row_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fs_d    = 1'b0;
      rd_d1_d = mem_rd_en;
      pv_d    = rd_d1_q;
      pix_d   = rd_d1_q ? mem_rd_data : pix_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SOF;
            busy_d  = 1'b1;
            fs_d    = 1'b1;
         end
         SOF: state_d = STREAM;
         STREAM: if (!pause) begin
            addr_d = addr_q + 1'b1;
            col_d  = col_last ? '0 : col_q + 1'b1;
            row_d  = col_last ? row_q + 1'b1 : row_q;
            if (col_last && row_last) begin
               state_d = DRAIN;
               addr_d  = '0;
               row_d   = '0;
            end else if (GAP_EN && col_last) begin
               state_d = GAP;
               gap_d   = '0;
            end
         end
         GAP: begin
            gap_d   = gap_q + 1'b1;
            state_d = gap_q == GW'(ROW_GAP - 1) ? STREAM : GAP;
         end
         // the final read has left the pipeline once rd_d1 is clear and its beat is on the output
         DRAIN: if (!rd_d1_q && pv_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fs_q    <= 1'b0;
         rd_d1_q <= 1'b0;
         pv_q    <= 1'b0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fs_q    <= fs_d;
         rd_d1_q <= rd_d1_d;
         pv_q    <= pv_d;
         pix_q   <= pix_d;
      end
   end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: directed checks of pixel_streamer against a 1-cycle sync RAM holding mem[a]=a+1
module tb_pixel_streamer;
   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int AW = 5;
   localparam int N  = W * H;
`ifdef ROW_GAP_EN
   localparam int G = 2;
`else
   localparam int G = 0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          busy, done, mem_rd_en, frame_start, pixel_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] pixel_out;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            fs_q[$], fsb_q[$], dn_q[$], dnb_q[$], rd_q[$], ra_q[$], bc_q[$], bv_q[$];
   int            p, p2;
   pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .ROW_GAP(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .frame_start(frame_start), .pixel_out(pixel_out), .pixel_valid(pixel_valid)
   );
   always #5 clk = ~clk;
   initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (frame_start) begin fs_q.push_back(cyc); fsb_q.push_back(int'(busy)); end
      if (done) begin dn_q.push_back(cyc); dnb_q.push_back(int'(busy)); end
      if (mem_rd_en) begin rd_q.push_back(cyc); ra_q.push_back(int'(mem_addr)); end
      if (pixel_valid) begin bc_q.push_back(cyc); bv_q.push_back(int'(pixel_out)); end
      check("fs_pv_excl", {31'd0, frame_start & pixel_valid}, 0);
   end
   // beat i lands this many cycles after the frame_start cycle; hole = pause cycles after the 7th read
   function automatic int bt(input int i, input int hole);
      return 3 + i + G * (i / W) + (i >= 7 ? hole : 0);
   endfunction
   task automatic clear_q;
      fs_q.delete(); fsb_q.delete(); dn_q.delete(); dnb_q.delete();
      rd_q.delete(); ra_q.delete(); bc_q.delete(); bv_q.delete();
   endtask
   task automatic pulse_start;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask
   task automatic wait_fs(output int fp);
      fp = -1;
      for (int i = 0; i < 100 && fp < 0; i++) begin
         @(negedge clk);
         if (frame_start) fp = cyc;
      end
      if (fp < 0) check("fs_timeout", 0, 1);
   endtask
   task automatic wait_done;
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check("done_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 0);
      check({tag, "_fs"}, {31'd0, frame_start}, 0);
      check({tag, "_pv"}, {31'd0, pixel_valid}, 0);
      check({tag, "_pix"}, {24'd0, pixel_out}, 0);
   endtask
   task automatic check_beats(input string tag, input int fp, input int base, input int hole);
      if (bv_q.size() < base + N) begin
         check({tag, "_beat_cnt"}, bv_q.size(), base + N);
         return;
      end
      for (int i = 0; i < N; i++) begin
         check({tag, "_beat_val"}, bv_q[base + i], i + 1);
         check({tag, "_beat_cyc"}, bc_q[base + i] - fp, bt(i, hole));
      end
   endtask
   task automatic check_frame(input string tag, input int fp, input int hole);
      check({tag, "_fs_cnt"}, fs_q.size(), 1);
      check({tag, "_done_cnt"}, dn_q.size(), 1);
      check({tag, "_rd_cnt"}, rd_q.size(), N);
      check({tag, "_beat_cnt"}, bv_q.size(), N);
      if (fsb_q.size() > 0) check({tag, "_busy_at_fs"}, fsb_q[0], 1);
      if (dn_q.size() > 0) begin
         check({tag, "_done_cyc"}, dn_q[0] - fp, bt(N - 1, hole) + 1);
         check({tag, "_busy_at_done"}, dnb_q[0], 0);
      end
      if (rd_q.size() == N) begin
         check({tag, "_first_rd"}, rd_q[0] - fp, 1);
         for (int i = 0; i < N; i++) check({tag, "_rd_addr"}, ra_q[i], i);
      end
      check_beats(tag, fp, 0, hole);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      clear_q();
      pulse_start();
      wait_fs(p);
      wait_done();
      check_frame("basic", p, 0);
      clear_q();
      pulse_start();
      wait_fs(p);
      repeat (bt(6, 0) - 2) @(posedge clk);
      @(posedge clk); #1 pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pause_addr", {27'd0, mem_addr}, 7);
         check("pause_rd_en", {31'd0, mem_rd_en}, 0);
         if (i < 2) @(posedge clk);
      end
      @(posedge clk); #1 pause = 1'b0;
      wait_done();
      check_frame("pause", p, 3);
      if (bc_q.size() > 7) check("pause_hole", bc_q[7] - bc_q[6], 4 + (G > 0 && 7 % W == 0 ? G : 0));
      clear_q();
      pulse_start();
      wait_fs(p);
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check("busy_mid", {31'd0, busy}, 1);
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      repeat (40) @(negedge clk);
      check_frame("restart_ign", p, 0);
      clear_q();
      @(posedge clk); #1 start = 1'b1;
      wait_fs(p);
      wait_fs(p2);
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      check("b2b_fs_cnt", fs_q.size(), 2);
      check("b2b_done_cnt", dn_q.size(), 2);
      if (dn_q.size() > 0) check("b2b_retrigger", p2 - dn_q[0], 1);
      check("b2b_beat_cnt", bv_q.size(), 2 * N);
      check_beats("b2b_f1", p, 0, 0);
      check_beats("b2b_f2", p2, N, 0);
      clear_q();
      pulse_start();
      wait_fs(p);
      repeat (bt(11, 0)) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_idle("mid_rst");
      repeat (40) @(negedge clk);
      check("mid_rst_done", dn_q.size(), 0);
      check("mid_rst_beats", bv_q.size(), 12);
      clear_q();
      pulse_start();
      wait_fs(p);
      wait_done();
      check_frame("post_rst", p, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
